// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer register block.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2
   } apb_cpl_state_t;

   localparam int REG_ID_IDX = 0;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/apb_reg_bank.sv
// Word register bank: byte-strobed write port, asynchronous read mux and
// flattened export of every register to the peripheral logic.
module apb_reg_bank
   import apb_pkg::*;
#(
   parameter int          DATA_W   = 32,
   parameter int          NUM_REGS = 8,
   parameter int          IDX_W    = 3,
   parameter logic [31:0] ID_VALUE = 32'h0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         wr_en,
   input  logic [IDX_W-1:0]             wr_idx,
   input  logic [DATA_W-1:0]            wr_data,
   input  logic [DATA_W/8-1:0]          wr_strb,
   input  logic [IDX_W-1:0]             rd_idx,
   output logic [DATA_W-1:0]            rd_data,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

   logic [DATA_W-1:0] bank_q [NUM_REGS];
   logic [DATA_W-1:0] bank_d [NUM_REGS];

   always_comb begin
      bank_d = bank_q;
      if (wr_en) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wr_strb[b]) begin
               bank_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
         end
      end
      // The ID slot is a constant; any stray write to it is dropped here.
      bank_d[REG_ID_IDX] = ID_VALUE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            bank_q[i] <= (i == REG_ID_IDX) ? ID_VALUE : '0;
         end
      end else begin
         bank_q <= bank_d;
      end
   end

   assign rd_data = bank_q[rd_idx];

   genvar gi;
   for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign reg_q[gi*DATA_W +: DATA_W] = bank_q[gi];
   end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer with fixed wait states, address decode with error response,
// and a byte-strobed register bank exported on reg_q.
module apb_completer_regs
   import apb_pkg::*;
#(
   parameter int          ADDR_W      = 8,
   parameter int          DATA_W      = 32,
   parameter int          NUM_REGS    = 8,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA0B0_0001
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic                         PSELx,
   input  logic                         PENABLE,
   input  logic                         PWRITE,
   input  logic [ADDR_W-1:0]            PADDR,
   input  logic [DATA_W-1:0]            PWDATA,
   input  logic [DATA_W/8-1:0]          PSTRB,
   output logic [DATA_W-1:0]            PRDATA,
   output logic                         PREADY,
   output logic                         PSLVERR,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

   localparam int IDX_W      = ADDR_W - 2;
   localparam int BANK_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   apb_cpl_state_t        state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  write_q, write_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [DATA_W/8-1:0]   strb_q, strb_d;

   logic [IDX_W-1:0]      idx;
   logic                  err;
   logic                  wr_en;
   logic [DATA_W-1:0]     rd_data;

   // Decode works only on the request captured in the setup phase.
   assign idx = addr_q[ADDR_W-1:2];
   assign err = (addr_q[1:0] != 2'b00)
             || (int'(idx) >= NUM_REGS)
             || (write_q && (int'(idx) == REG_ID_IDX));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      wr_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (PSELx && !PENABLE) begin
               addr_d  = PADDR;
               write_d = PWRITE;
               wdata_d = PWDATA;
               strb_d  = PSTRB;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (!PSELx || !PENABLE) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            // A requester that dropped PSELx/PENABLE here has abandoned the transfer.
            wr_en   = PSELx && PENABLE && write_q && !err;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
      end
   end

   apb_reg_bank #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .IDX_W    (BANK_IDX_W),
      .ID_VALUE (ID_VALUE)
   ) u_bank (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .wr_en   (wr_en),
      .wr_idx  (idx[BANK_IDX_W-1:0]),
      .wr_data (wdata_q),
      .wr_strb (strb_q),
      .rd_idx  (idx[BANK_IDX_W-1:0]),
      .rd_data (rd_data),
      .reg_q   (reg_q)
   );

   assign PREADY  = (state_q == ST_ACCESS);
   assign PSLVERR = PREADY && err;
   assign PRDATA  = (PREADY && !err) ? rd_data : '0;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Randomized bench for apb_completer_regs: three instances (2, 0 and 3 wait
// states) share the APB bus and are checked against an array-based model.
module tb_apb_completer_regs;

   localparam logic [31:0] ID = 32'hA0B0_0001;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [2:0]  psel;
   logic        penable, pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic [31:0]  prdata  [3];
   logic         pready  [3];
   logic         pslverr [3];
   logic [255:0] rq      [3];

   int          waits [3] = '{2, 0, 3};
   logic [31:0] mdl [3][8];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc_cnt  = 0;

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc_cnt <= cyc_cnt + 1;

   genvar gi;
   for (gi = 0; gi < 3; gi++) begin : g_dut
      apb_completer_regs #(
         .ADDR_W      (8),
         .DATA_W      (32),
         .NUM_REGS    (8),
         .WAIT_CYCLES ((gi == 0) ? 2 : (gi == 1) ? 0 : 3),
         .ID_VALUE    (ID)
      ) u_dut (
         .HCLK    (HCLK),
         .HRESETn (HRESETn),
         .PSELx   (psel[gi]),
         .PENABLE (penable),
         .PWRITE  (pwrite),
         .PADDR   (paddr),
         .PWDATA  (pwdata),
         .PSTRB   (pstrb),
         .PRDATA  (prdata[gi]),
         .PREADY  (pready[gi]),
         .PSLVERR (pslverr[gi]),
         .reg_q   (rq[gi])
      );
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [255:0] flat(input int d);
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = (i == 0) ? ID : mdl[d][i];
      return v;
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 8; i++) mdl[d][i] = '0;
   endtask

   // One complete transfer; called just after a rising edge, returns just after one.
   task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                           input logic [31:0] data, input logic [3:0] strb, output int rdy_at);
      int          idx;
      logic        err;
      logic [31:0] exp_rd;
      int          cyc;
      idx    = int'(addr[7:2]);
      err    = (addr[1:0] != 2'b00) || (idx >= 8) || (wr && idx == 0);
      exp_rd = err ? 32'h0 : ((idx == 0) ? ID : mdl[d][idx]);
      psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
      paddr = addr; pwdata = data; pstrb = strb;
      @(posedge HCLK); #1;
      penable = 1'b1;
      paddr = 8'($urandom); pwdata = $urandom; pstrb = 4'($urandom);
      cyc = 2;
      @(negedge HCLK);
      while (!pready[d] && cyc < 24) begin
         chk("rdata_when_not_ready", prdata[d], 32'h0);
         @(negedge HCLK);
         cyc++;
      end
      rdy_at = cyc_cnt;
      chk("latency", cyc, 2 + waits[d]);
      chk("pslverr", pslverr[d], err);
      if (!wr || err) chk("prdata", prdata[d], exp_rd);
      $display("xfer dut%0d %s addr=%h data=%h strb=%h err=%0d rdata=%h lat=%0d",
               d, wr ? "WR" : "RD", addr, data, strb, err, prdata[d], cyc);
      if (wr && !err)
         for (int k = 0; k < 4; k++)
            if (strb[k]) mdl[d][idx][8*k +: 8] = data[8*k +: 8];
      @(posedge HCLK); #1;
      psel = '0; penable = 1'b0;
      chk("reg_q", rq[d], flat(d));
   endtask

   initial begin
      int r0, r1, prev;
      int d;
      logic [7:0] a;
      HRESETn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      clear_model();

      // Reset state of all instances
      repeat (3) @(posedge HCLK);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_pready", pready[i], 1'b0);
         chk("rst_pslverr", pslverr[i], 1'b0);
         chk("rst_prdata", prdata[i], 32'h0);
         chk("rst_reg_q", rq[i], flat(i));
      end
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Two wait states: full write, readback, ID read, strobed write, errors
      apb_xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, r0);
      @(negedge HCLK) chk("ready_one_cycle", pready[0], 1'b0);
      chk("reg1_value", rq[0][63:32], 32'hDEADBEEF);
      @(posedge HCLK); #1;
      apb_xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, r0);
      apb_xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, r0);
      apb_xfer(0, 1'b1, 8'h08, 32'h11223344, 4'b0101, r0);
      chk("reg2_strobed", rq[0][95:64], 32'h00220044);
      apb_xfer(0, 1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, r0);
      apb_xfer(0, 1'b0, 8'h20, 32'h0, 4'h0, r0);
      apb_xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, r0);
      apb_xfer(0, 1'b1, 8'h0C, 32'h12345678, 4'h0, r0);

      // Reset asserted in the middle of a wait phase
      psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'h10; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
      @(posedge HCLK); #1 penable = 1'b1;
      @(posedge HCLK); #1 HRESETn = 1'b0;
      clear_model();
      #1;
      chk("midrst_pready", pready[0], 1'b0);
      chk("midrst_pslverr", pslverr[0], 1'b0);
      chk("midrst_prdata", prdata[0], 32'h0);
      chk("midrst_rw_regs", rq[0][255:32], 224'h0);
      chk("midrst_reg_q", rq[0], flat(0));
      psel = '0; penable = 1'b0;
      @(negedge HCLK) HRESETn = 1'b1;
      @(posedge HCLK); #1;
      chk("midrst_no_write", rq[0], flat(0));

      // Zero wait states, back-to-back transfers with no bubble
      prev = 0;
      for (int i = 0; i < 6; i++) begin
         apb_xfer(1, (i % 2) == 0, 8'(4 * (1 + (i / 2))), $urandom, 4'hF, r1);
         if (i > 0) chk("b2b_gap", r1 - prev, 2);
         prev = r1;
      end

      // Three wait states: select dropped during wait aborts the write
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 8'h18; pwdata = 32'hA5A5A5A5; pstrb = 4'hF;
      @(posedge HCLK); #1 penable = 1'b1;
      @(posedge HCLK); #1 psel = '0; penable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge HCLK);
         chk("abort_pready", pready[2], 1'b0);
      end
      chk("abort_no_write", rq[2], flat(2));
      @(posedge HCLK); #1;
      apb_xfer(2, 1'b1, 8'h18, 32'h5A5A5A5A, 4'hF, r0);
      apb_xfer(2, 1'b0, 8'h18, 32'h0, 4'h0, r0);

      // Randomized traffic across all instances
      for (int i = 0; i < 80; i++) begin
         d = $urandom_range(0, 2);
         a = 8'(4 * $urandom_range(0, 9));
         if ($urandom_range(0, 7) == 0) a = a + 8'($urandom_range(1, 3));
         apb_xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), r0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
